// File: rtl/spi_interface_slave.sv
// SPI slave endpoint: oversamples sck/cs/mosi in the clk domain, shifts mosi into dout and din onto miso.
// Optional SPI_SLAVE_ABORT_FLAG_EN adds frame_abort / abort_bits reporting for frames cut short by cs.
module spi_interface_slave #(
    parameter int SPI_MAX_WIDTH_LOG = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                sck,
    input  logic                                cs,
    input  logic                                mosi,
    output logic                                miso,
    input  logic                                config_req,
    input  logic [SPI_MAX_WIDTH_LOG+1:0]        config_data,
    input  logic [(1<<SPI_MAX_WIDTH_LOG)-1:0]   din,
    output logic [(1<<SPI_MAX_WIDTH_LOG)-1:0]   dout,
    output logic                                dout_valid,
    output logic                                busy
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    ,
    output logic                                frame_abort,
    output logic [SPI_MAX_WIDTH_LOG:0]          abort_bits
`endif
);
    localparam int SMWL = SPI_MAX_WIDTH_LOG;
    localparam int DW   = 1 << SMWL;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, WAIT_CS} state_t;

    logic            sck_s1_q, sck_s2_q, sck_d_q;
    logic            cs_s1_q, cs_s2_q, cs_d_q;
    logic            mosi_s1_q, mosi_s2_q;
    state_t          state_q, state_d;
    logic            cpol_q, cpol_d, cpha_q, cpha_d;
    logic [SMWL-1:0] width_q, width_d;
    logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [SMWL:0]   cnt_q, cnt_d;
    logic            miso_q, miso_d, dout_valid_q, dout_valid_d, busy_q, busy_d;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    logic            abort_q, abort_d;
    logic [SMWL:0]   abort_bits_q, abort_bits_d;
`endif

    logic            sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
    logic [SMWL-1:0] tx_idx;

    assign sck_rise    = sck_s2_q & ~sck_d_q;
    assign sck_fall    = ~sck_s2_q & sck_d_q;
    assign lead_edge   = cpol_q ? sck_fall : sck_rise;
    assign trail_edge  = cpol_q ? sck_rise : sck_fall;
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_d_q & ~cs_s2_q;
    // Next bit to present is the MSB minus the number of bits already sampled.
    assign tx_idx      = width_q - cnt_q[SMWL-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_d_q   <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_d_q    <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_d_q   <= sck_s2_q;
            cs_s1_q   <= cs;
            cs_s2_q   <= cs_s1_q;
            cs_d_q    <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            width_q      <= '1;
            tx_q         <= '0;
            rx_q         <= '0;
            dout_q       <= '0;
            cnt_q        <= '0;
            miso_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            abort_q      <= 1'b0;
            abort_bits_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            width_q      <= width_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            dout_q       <= dout_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            dout_valid_q <= dout_valid_d;
            busy_q       <= busy_d;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
            abort_q      <= abort_d;
            abort_bits_q <= abort_bits_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cpol_d       = cpol_q;
        cpha_d       = cpha_q;
        width_d      = width_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        dout_d       = dout_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        dout_valid_d = 1'b0;
        busy_d       = busy_q;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        abort_d      = 1'b0;
        abort_bits_d = abort_bits_q;
`endif
        case (state_q)
            IDLE: begin
                // A config written in the same cycle as cs falling applies to that frame.
                if (config_req) begin
                    {cpol_d, cpha_d, width_d} = config_data;
                end
                if (cs_fall) begin
                    state_d = ACTIVE;
                    tx_d    = din;
                    rx_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    if (!cpha_d) begin
                        miso_d = din[width_d];
                    end
                end
            end
            ACTIVE: begin
                if (cs_s2_q) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    busy_d  = 1'b0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
                    abort_d      = 1'b1;
                    abort_bits_d = cnt_q;
`endif
                end else if (sample_edge) begin
                    rx_d  = {rx_q[DW-2:0], mosi_s2_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == {1'b0, width_q}) begin
                        state_d = DONE;
                    end
                end else if (shift_edge) begin
                    miso_d = tx_q[tx_idx];
                end
            end
            DONE: begin
                dout_d       = rx_q;
                dout_valid_d = 1'b1;
                state_d      = WAIT_CS;
            end
            WAIT_CS: begin
                if (cs_s2_q) begin
                    busy_d  = 1'b0;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign miso       = miso_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    assign frame_abort = abort_q;
    assign abort_bits  = abort_bits_q;
`endif

endmodule

// File: tb/tb_spi_interface_slave.sv
// Bench for spi_interface_slave: an SPI master model drives frames in all modes and widths,
// and received/transmitted words are compared against masked reference values.
module tb_spi_interface_slave;
    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst_n, sck, cs, mosi, config_req;
    logic [5:0]  config_data;
    logic [15:0] din;
    logic        miso, dout_valid, busy;
    logic [15:0] dout;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
    logic        frame_abort;
    logic [4:0]  abort_bits;
    int          abort_total = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          vld_total = 0;
    logic [15:0] exp_dout = 16'h0;

    spi_interface_slave dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
        .config_req(config_req), .config_data(config_data), .din(din),
        .dout(dout), .dout_valid(dout_valid), .busy(busy)
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        , .frame_abort(frame_abort), .abort_bits(abort_bits)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dout_valid === 1'b1) vld_total <= vld_total + 1;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        if (frame_abort === 1'b1) abort_total <= abort_total + 1;
`endif
    end

    task automatic set_cfg(input logic p, input logic h, input logic [3:0] w);
        @(negedge clk);
        config_req  = 1'b1;
        config_data = {p, h, w};
        @(negedge clk);
        config_req  = 1'b0;
    endtask

    // Master model: mosi/miso MSB first, sample on leading (cpha=0) or trailing (cpha=1) edge.
    task automatic spi_frame(input logic p, input logic h, input int nbits, input logic [15:0] tx,
                             input int stop_after, input int extra, input bit mid_cfg,
                             output logic [15:0] rx, output logic busy_mid);
        rx  = 16'h0;
        sck = p;
        cs  = 1'b0;
        #160;
        busy_mid = busy;
        for (int i = 0; i < nbits; i++) begin
            if (i == stop_after) break;
            if (!h) mosi = tx[nbits-1-i];
            #HALF;
            if (!h) rx = {rx[14:0], miso};
            sck = ~p;
            if (h) mosi = tx[nbits-1-i];
            #HALF;
            if (h) rx = {rx[14:0], miso};
            sck = p;
            if (mid_cfg && i == 2) set_cfg(1'b0, 1'b1, 4'd3);
        end
        for (int e = 0; e < extra; e++) begin
            #HALF; sck = ~p;
            #HALF; sck = p;
        end
        #HALF;
        cs = 1'b1;
        #240;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; config_req = 1'b0;
        config_data = 6'h0; din = 16'h0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso); end
        if (dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
        if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        checks++;
        if (frame_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b exp 0", frame_abort); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_w7;
        logic [15:0] rx; logic bm; int v0;
        sck = 1'b0;
        set_cfg(1'b0, 1'b0, 4'd7);
        din = 16'h003C; v0 = vld_total;
        spi_frame(1'b0, 1'b0, 8, 16'h00A5, -1, 0, 1'b0, rx, bm);
        exp_dout = 16'h00A5;
        checks += 6;
        if (bm !== 1'b1) begin errors++; $display("FAIL m0_busy_mid got %b exp 1", bm); end
        if (dout !== exp_dout) begin errors++; $display("FAIL m0_dout got %h exp %h", dout, exp_dout); end
        if (vld_total - v0 != 1) begin errors++; $display("FAIL m0_valid_count got %0d exp 1", vld_total - v0); end
        if (rx !== 16'h003C) begin errors++; $display("FAIL m0_master_rx got %h exp 003c", rx); end
        if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end got %b exp 0", busy); end
        if (miso !== 1'b0) begin errors++; $display("FAIL m0_miso_end got %b exp 0", miso); end
    endtask

    task automatic test_modes_w15;
        logic [15:0] rx; logic bm; int v0;
        for (int m = 1; m < 4; m++) begin
            sck = m[1];
            set_cfg(m[1], m[0], 4'd15);
            din = 16'hBEEF; v0 = vld_total;
            spi_frame(m[1], m[0], 16, 16'h1234, -1, 0, 1'b0, rx, bm);
            exp_dout = 16'h1234;
            checks += 3;
            if (dout !== exp_dout) begin errors++; $display("FAIL mode%0d_dout got %h exp %h", m, dout, exp_dout); end
            if (rx !== 16'hBEEF) begin errors++; $display("FAIL mode%0d_master_rx got %h exp beef", m, rx); end
            if (vld_total - v0 != 1) begin errors++; $display("FAIL mode%0d_valid_count got %0d exp 1", m, vld_total - v0); end
        end
    endtask

    task automatic test_width0;
        logic [15:0] rx; logic bm; int v0;
        sck = 1'b0;
        set_cfg(1'b0, 1'b1, 4'd0);
        din = 16'hFFFE; v0 = vld_total;
        spi_frame(1'b0, 1'b1, 1, 16'h0001, -1, 0, 1'b0, rx, bm);
        exp_dout = 16'h0001;
        checks += 3;
        if (dout !== exp_dout) begin errors++; $display("FAIL w0_dout got %h exp %h", dout, exp_dout); end
        if (rx !== 16'h0000) begin errors++; $display("FAIL w0_master_rx got %h exp 0000", rx); end
        if (vld_total - v0 != 1) begin errors++; $display("FAIL w0_valid_count got %0d exp 1", vld_total - v0); end
    endtask

    task automatic test_abort;
        logic [15:0] rx; logic bm; int v0;
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        int a0 = abort_total;
`endif
        sck = 1'b0;
        set_cfg(1'b0, 1'b0, 4'd7);
        din = 16'($urandom); v0 = vld_total;
        spi_frame(1'b0, 1'b0, 8, 16'($urandom), 3, 0, 1'b0, rx, bm);
        checks += 4;
        if (vld_total - v0 != 0) begin errors++; $display("FAIL abort_valid_count got %0d exp 0", vld_total - v0); end
        if (dout !== exp_dout) begin errors++; $display("FAIL abort_dout got %h exp %h", dout, exp_dout); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        if (miso !== 1'b0) begin errors++; $display("FAIL abort_miso got %b exp 0", miso); end
`ifdef SPI_SLAVE_ABORT_FLAG_EN
        checks += 2;
        if (abort_total - a0 != 1) begin errors++; $display("FAIL abort_pulses got %0d exp 1", abort_total - a0); end
        if (abort_bits !== 5'd3) begin errors++; $display("FAIL abort_bits got %0d exp 3", abort_bits); end
`endif
    endtask

    task automatic test_config_busy;
        logic [15:0] rx; logic bm; int v0;
        din = 16'h005A; v0 = vld_total;
        spi_frame(1'b0, 1'b0, 8, 16'h00C3, -1, 0, 1'b1, rx, bm);
        exp_dout = 16'h00C3;
        checks += 3;
        if (dout !== exp_dout) begin errors++; $display("FAIL cfgbusy_dout got %h exp %h", dout, exp_dout); end
        if (rx !== 16'h005A) begin errors++; $display("FAIL cfgbusy_master_rx got %h exp 005a", rx); end
        if (vld_total - v0 != 1) begin errors++; $display("FAIL cfgbusy_valid_count got %0d exp 1", vld_total - v0); end
        din = 16'h0081;
        spi_frame(1'b0, 1'b0, 8, 16'h007E, -1, 0, 1'b0, rx, bm);
        exp_dout = 16'h007E;
        checks += 2;
        if (dout !== exp_dout) begin errors++; $display("FAIL cfgnext_dout got %h exp %h", dout, exp_dout); end
        if (rx !== 16'h0081) begin errors++; $display("FAIL cfgnext_master_rx got %h exp 0081", rx); end
    endtask

    task automatic test_extra_edges;
        logic [15:0] rx; logic bm; int v0;
        din = 16'h00F0; v0 = vld_total;
        spi_frame(1'b0, 1'b0, 8, 16'h0033, -1, 3, 1'b0, rx, bm);
        exp_dout = 16'h0033;
        checks += 2;
        if (dout !== exp_dout) begin errors++; $display("FAIL extra_dout got %h exp %h", dout, exp_dout); end
        if (vld_total - v0 != 1) begin errors++; $display("FAIL extra_valid_count got %0d exp 1", vld_total - v0); end
    endtask

    task automatic test_random;
        logic [15:0] rx, tx, mask; logic bm; logic p, h; logic [3:0] w; logic [31:0] m32; int v0;
        for (int n = 0; n < 10; n++) begin
            p = 1'($urandom); h = 1'($urandom); w = 4'($urandom_range(0, 15));
            m32 = (32'h1 << (w + 1)) - 32'h1;
            mask = m32[15:0];
            tx = 16'($urandom); din = 16'($urandom);
            sck = p;
            set_cfg(p, h, w);
            v0 = vld_total;
            spi_frame(p, h, int'(w) + 1, tx, -1, 0, 1'b0, rx, bm);
            exp_dout = tx & mask;
            checks += 3;
            if (dout !== exp_dout) begin errors++; $display("FAIL rand%0d_dout mode %b%b w %0d got %h exp %h", n, p, h, w, dout, exp_dout); end
            if (rx !== (din & mask)) begin errors++; $display("FAIL rand%0d_master_rx got %h exp %h", n, rx, din & mask); end
            if (vld_total - v0 != 1) begin errors++; $display("FAIL rand%0d_valid_count got %0d exp 1", n, vld_total - v0); end
        end
    endtask

    task automatic test_reset_mid;
        logic [15:0] rx, tx; logic bm;
        sck = 1'b0;
        set_cfg(1'b0, 1'b0, 4'd7);
        din = 16'h00FF;
        cs = 1'b0;
        #160;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #HALF; sck = 1'b1;
            #HALF; sck = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 3;
        if (dout !== 16'h0) begin errors++; $display("FAIL rstmid_dout got %h exp 0000", dout); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        if (miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso got %b exp 0", miso); end
        @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        // Reset configuration is mode 0 with a full 16-bit frame.
        tx = 16'($urandom); din = 16'($urandom);
        spi_frame(1'b0, 1'b0, 16, tx, -1, 0, 1'b0, rx, bm);
        exp_dout = tx;
        checks += 2;
        if (dout !== exp_dout) begin errors++; $display("FAIL postrst_dout got %h exp %h", dout, exp_dout); end
        if (rx !== din) begin errors++; $display("FAIL postrst_master_rx got %h exp %h", rx, din); end
    endtask

    initial begin
        test_reset();
        test_mode0_w7();
        test_modes_w15();
        test_width0();
        test_abort();
        set_cfg(1'b0, 1'b0, 4'd7);
        test_config_busy();
        test_extra_edges();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
